dual_port_ram_be: RTL

//  True dual-port word RAM: two independent read/write ports, per-byte write strobes, parametrised width/depth.

---
 rtl/dual_port_ram_be.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be
//   True dual-port word RAM with per-byte write strobes. Shared instruction/
//   data store: port 1 is the data side, port 2 the fetch/DMA side. Has an
//   optional output register stage, read-valid and address-error pulses, and
//   an optional clear sequence that zeroes every word after reset release.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   init_busy                  high while the clear sequence runs
//   write_N, read_N            port N write / read request
//   address_N   [ADDR_W]       port N byte address (must be word aligned)
//   byte_en_N   [DATA_W/8]     port N write strobes, bit i = byte lane i
//   write_data_N[DATA_W]       port N write data
//   read_data_N [DATA_W]       port N read data, holds while read_valid_N is low
//   read_valid_N               one pulse per accepted read
//   addr_err_N                 pulse for a misaligned or out-of-range request
module dual_port_ram_be #(
    parameter int DATA_W        = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int ADDR_W        = 32,
    parameter int OUT_REG       = 0,
    parameter int RDW_MODE      = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                init_busy,
    input  logic                write_1,
    input  logic                read_1,
    input  logic [ADDR_W-1:0]   address_1,
    input  logic [DATA_W/8-1:0] byte_en_1,
    input  logic [DATA_W-1:0]   write_data_1,
    output logic [DATA_W-1:0]   read_data_1,
    output logic                read_valid_1,
    output logic                addr_err_1,
    input  logic                write_2,
    input  logic                read_2,
    input  logic [ADDR_W-1:0]   address_2,
    input  logic [DATA_W/8-1:0] byte_en_2,
    input  logic [DATA_W-1:0]   write_data_2,
    output logic [DATA_W-1:0]   read_data_2,
    output logic                read_valid_2,
    output logic                addr_err_2
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [IDX_W-1:0]  cnt;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Both ports folded into 2-entry arrays; index 0 = port 1, index 1 = port 2.
    logic              wr      [2];
    logic              rd      [2];
    logic [ADDR_W-1:0] addr    [2];
    logic [BYTES-1:0]  be      [2];
    logic [DATA_W-1:0] wd      [2];
    logic [ADDR_W-1:0] word    [2];
    logic [IDX_W-1:0]  idx     [2];
    logic              err     [2];
    logic              wr_ok   [2];
    logic              rd_ok   [2];
    logic [DATA_W-1:0] rd_word [2];

    logic [DATA_W-1:0] s1_data [2];
    logic              s1_vld  [2];
    logic              s1_err  [2];
    logic [DATA_W-1:0] o_data  [2];
    logic              o_vld   [2];
    logic              o_err   [2];

    assign wr[0]   = write_1;
    assign rd[0]   = read_1;
    assign addr[0] = address_1;
    assign be[0]   = byte_en_1;
    assign wd[0]   = write_data_1;
    assign wr[1]   = write_2;
    assign rd[1]   = read_2;
    assign addr[1] = address_2;
    assign be[1]   = byte_en_2;
    assign wd[1]   = write_data_2;

    // Request decode; nothing is accepted or flagged while clearing.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            word[p]  = addr[p] >> OFF_W;
            idx[p]   = word[p][IDX_W-1:0];
            err[p]   = (state == IDLE) && (wr[p] || rd[p]) &&
                       (((addr[p] & ADDR_W'(BYTES - 1)) != '0) ||
                        (word[p] >= ADDR_W'(MEM_DEPTH)));
            wr_ok[p] = (state == IDLE) && wr[p] && !err[p];
            rd_ok[p] = (state == IDLE) && rd[p] && !err[p];
        end
    end

    // Read word; RDW_MODE=1 merges this port's own enabled write lanes.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd_word[p] = mem[idx[p]];
            if (RDW_MODE != 0 && wr_ok[p]) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (be[p][i]) rd_word[p][i*8 +: 8] = wd[p][i*8 +: 8];
                end
            end
        end
    end

    // Clear sequencer: one word per cycle, init_busy mirrors the CLEAR state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
            cnt       <= '0;
            init_busy <= (INIT_ON_RESET != 0);
        end else if (state == CLEAR) begin
            if (cnt == IDX_W'(MEM_DEPTH - 1)) begin
                state     <= IDLE;
                init_busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Array write. Port 2 is assigned first so port 1 wins any lane both
    // ports enable on the same word.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wr_ok[1] && be[1][i]) mem[idx[1]][i*8 +: 8] <= wd[1][i*8 +: 8];
                if (wr_ok[0] && be[0][i]) mem[idx[0]][i*8 +: 8] <= wd[0][i*8 +: 8];
            end
        end
    end

    // First read stage; data only moves on an accepted read so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < 2; p++) begin
                s1_data[p] <= '0;
                s1_vld[p]  <= 1'b0;
                s1_err[p]  <= 1'b0;
            end
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                s1_vld[p] <= rd_ok[p];
                s1_err[p] <= err[p];
                if (rd_ok[p]) s1_data[p] <= rd_word[p];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] s2_data [2];
        logic              s2_vld  [2];
        logic              s2_err  [2];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    s2_data[p] <= '0;
                    s2_vld[p]  <= 1'b0;
                    s2_err[p]  <= 1'b0;
                end
            end else begin
                for (int unsigned p = 0; p < 2; p++) begin
                    s2_vld[p] <= s1_vld[p];
                    s2_err[p] <= s1_err[p];
                    if (s1_vld[p]) s2_data[p] <= s1_data[p];
                end
            end
        end

        assign o_data = s2_data;
        assign o_vld  = s2_vld;
        assign o_err  = s2_err;
    end else begin : g_no_out_reg
        assign o_data = s1_data;
        assign o_vld  = s1_vld;
        assign o_err  = s1_err;
    end

    assign read_data_1  = o_data[0];
    assign read_valid_1 = o_vld[0];
    assign addr_err_1   = o_err[0];
    assign read_data_2  = o_data[1];
    assign read_valid_2 = o_vld[1];
    assign addr_err_2   = o_err[1];

endmodule
